mux_tree_pipe: RTL and testbench

//   Parametrised N:1 multiplexer (N = 2**SEL_BITS) for WIDTH-bit buses, built as a binary tree
//   of 2:1 levels with optional pipeline registers between levels and a valid/ready handshake.

---
 rtl/mux_tree_pipe_pkg.sv | 11 +
 rtl/mux_tree_pipe_level.sv | 66 ++++++
 rtl/mux_tree_pipe.sv | 65 ++++++
 tb/tb_mux_tree_pipe.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_tree_pipe_pkg.sv
// rtl/mux_tree_pipe_pkg.sv - shared constants and helpers for the pipelined mux tree
package mux_tree_pipe_pkg;

  localparam int MUX_MAX_SEL_BITS = 5;

  // Number of lanes entering tree level k of a 2**sel_bits input tree.
  function automatic int lanes_at(input int sel_bits, input int k);
    return 1 << (sel_bits - k);
  endfunction

endpackage

// File: rtl/mux_tree_pipe_level.sv
// rtl/mux_tree_pipe_level.sv - one 2:1 level of the mux tree, optionally registered
module mux_tree_level
  import mux_tree_pipe_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int LANES_IN = 2,
  parameter int SB       = 1,
  parameter bit REG      = 1'b1
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          en_i,
  input  logic                          valid_i,
  input  logic [SB-1:0]                 sel_i,
  input  logic [LANES_IN*WIDTH-1:0]     data_i,
  output logic                          valid_o,
  output logic [SB-1:0]                 sel_o,
  output logic [(LANES_IN/2)*WIDTH-1:0] data_o
);

  localparam int LANES_OUT = LANES_IN / 2;

  logic [LANES_OUT*WIDTH-1:0] data_d;
  logic [SB-1:0]              sel_d;

  // Bit 0 steers this level; the rest shifts down so the next level always uses bit 0.
  always_comb begin
    data_d = '0;
    for (int j = 0; j < LANES_OUT; j++) begin
      data_d[j*WIDTH +: WIDTH] = sel_i[0] ? data_i[(2*j+1)*WIDTH +: WIDTH]
                                          : data_i[(2*j)*WIDTH +: WIDTH];
    end
    sel_d = sel_i >> 1;
  end

  generate
    if (REG) begin : g_reg
      logic                       valid_q;
      logic [SB-1:0]              sel_q;
      logic [LANES_OUT*WIDTH-1:0] data_q;

      always_ff @(posedge clock_i) begin
        if (reset_i) begin
          valid_q <= 1'b0;
          sel_q   <= '0;
          data_q  <= '0;
        end else if (en_i) begin
          valid_q <= valid_i;
          sel_q   <= sel_d;
          data_q  <= data_d;
        end
      end

      assign valid_o = valid_q;
      assign sel_o   = sel_q;
      assign data_o  = data_q;
    end else begin : g_comb
      logic unused_ok;
      assign unused_ok = &{1'b0, clock_i, reset_i, en_i};
      assign valid_o   = valid_i;
      assign sel_o     = sel_d;
      assign data_o    = data_d;
    end
  endgenerate

endmodule

// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - N:1 wide mux tree with per-level pipelining and valid/ready handshake
module mux_tree_pipe
  import mux_tree_pipe_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SEL_BITS = 3,
  parameter bit PIPE     = 1'b1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SEL_BITS-1:0]              select,
  input  logic [(1<<SEL_BITS)*WIDTH-1:0]   in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data
);

  localparam int N = 1 << SEL_BITS;

  logic [SEL_BITS:0]                valid_w;
  logic [SEL_BITS:0][SEL_BITS-1:0]  sel_w;
  logic [SEL_BITS:0][N*WIDTH-1:0]   data_w;
  logic                             stall;
  logic                             unused_ok;

  assign valid_w[0] = in_valid;
  assign sel_w[0]   = select;
  assign data_w[0]  = in_data;

  // Without PIPE only the last level registers, giving the single output register.
  generate
    for (genvar k = 0; k < SEL_BITS; k++) begin : g_level
      localparam int LIN   = lanes_at(SEL_BITS, k);
      localparam int OUT_W = (LIN / 2) * WIDTH;

      mux_tree_level #(
        .WIDTH    (WIDTH),
        .LANES_IN (LIN),
        .SB       (SEL_BITS),
        .REG      (PIPE || (k == SEL_BITS - 1))
      ) u_level (
        .clock_i (clock),
        .reset_i (reset),
        .en_i    (~stall),
        .valid_i (valid_w[k]),
        .sel_i   (sel_w[k]),
        .data_i  (data_w[k][LIN*WIDTH-1:0]),
        .valid_o (valid_w[k+1]),
        .sel_o   (sel_w[k+1]),
        .data_o  (data_w[k+1][OUT_W-1:0])
      );

      assign data_w[k+1][N*WIDTH-1:OUT_W] = '0;
    end
  endgenerate

  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = valid_w[SEL_BITS];
  assign out_data  = data_w[SEL_BITS][WIDTH-1:0];
  assign unused_ok = ^{1'b0, sel_w[SEL_BITS], data_w};

endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb/tb_mux_tree_pipe.sv - scoreboard bench for mux_tree_pipe over several configurations
module tb_mux_tree_pipe;

  localparam int NCFG = 4;
  localparam int CW [NCFG] = '{32, 32, 16, 8};
  localparam int CS [NCFG] = '{3, 3, 1, 5};
  localparam bit CP [NCFG] = '{1'b1, 1'b0, 1'b1, 1'b1};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int W  = CW[g];
    localparam int SB = CS[g];
    localparam int N  = 1 << SB;
    localparam int L  = CP[g] ? SB : 1;

    typedef struct {
      logic [W-1:0] d;
      int           stamp;
      bit           lat;
      bit           seen;
    } exp_t;

    logic            reset, in_valid, in_ready, out_valid, out_ready;
    logic [SB-1:0]   select;
    logic [N*W-1:0]  in_data;
    logic [W-1:0]    out_data;
    logic [W-1:0]    lanes [N];
    exp_t            q [$];
    int              cyc  = 0;
    int              nacc = 0;
    bit              lat_chk = 1'b0;
    bit              done = 1'b0;
    bit              dir_done = (g != 0);

    always_comb begin
      in_data = '0;
      for (int k = 0; k < N; k++) in_data[k*W +: W] = lanes[k];
    end

    mux_tree_pipe #(.WIDTH(W), .SEL_BITS(SB), .PIPE(CP[g])) u_dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .select    (select),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
    );

    // Reference: an accepted beat is simply the selected lane, captured at acceptance.
    always @(posedge clock) begin
      cyc <= cyc + 1;
      if (reset) q.delete();
      else if (in_valid && in_ready) begin
        q.push_back('{d: lanes[select], stamp: cyc, lat: lat_chk, seen: 1'b0});
        nacc <= nacc + 1;
      end
    end

    always @(negedge clock) begin
      if (cyc > 0 && out_valid) begin
        if (q.size() == 0) check($sformatf("c%0d_spurious_beat", g), q.size(), 1);
        else begin
          check($sformatf("c%0d_data", g), out_data, q[0].d);
          if (q[0].lat && !q[0].seen) check($sformatf("c%0d_latency", g), cyc - q[0].stamp, L);
          q[0].seen = 1'b1;
          if (out_ready) void'(q.pop_front());
        end
      end
    end

    task automatic drain(input string tag);
      for (int i = 0; i < 60 && q.size() != 0; i++) tick();
      check(tag, q.size(), 0);
    endtask

    task automatic send(input logic [SB-1:0] s);
      bit ok = 1'b0;
      in_valid = 1'b1;
      select   = s;
      for (int i = 0; i < 40 && !ok; i++) begin
        @(negedge clock);
        ok = in_ready;
        tick();
      end
      check("send_accepted", ok, 1);
    endtask

    if (g == 0) begin : g_directed
      initial begin
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; select = '0; lat_chk = 1'b0;
        for (int k = 0; k < N; k++) lanes[k] = W'(32'hA000_0000 + k);
        for (int i = 0; i < 3; i++) begin
          tick();
          if (i == 1) begin reset = 1'b0; in_valid = 1'b0; end
          @(negedge clock);
          check("rst_out_valid", out_valid, 0);
          check("rst_out_data", out_data, 0);
        end
        tick();

        lat_chk = 1'b1;
        for (int s = 0; s < N; s++) begin
          in_valid = 1'b1; select = SB'(s); tick();
        end
        in_valid = 1'b0; lat_chk = 1'b0;
        drain("sweep_drain");

        fork
          begin
            send(SB'(1)); send(SB'(6)); send(SB'(2)); send(SB'(4));
            in_valid = 1'b0;
          end
          begin
            for (int t = 0; t < 8; t++) begin
              out_ready = !(t >= 3 && t <= 6);
              @(negedge clock);
              if (t >= 3 && t <= 6) check("stall_in_ready", in_ready, 0);
              tick();
            end
            out_ready = 1'b1;
          end
        join
        drain("backpressure_drain");

        select = SB'(5);
        fork
          for (int t = 0; t < 4; t++) begin
            in_valid = (t % 2 == 0); tick();
          end
          begin
            repeat (3) tick();
            for (int i = 0; i < 4; i++) begin
              @(negedge clock);
              check("bubble_out_valid", out_valid, (i % 2 == 0));
              tick();
            end
          end
        join
        in_valid = 1'b0;
        drain("bubble_drain");

        select = SB'(7); in_valid = 1'b1; tick();
        select = SB'(0); tick();
        select = SB'(3); reset = 1'b1; tick();
        reset = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
          @(negedge clock);
          check("flush_out_valid", out_valid, 0);
          tick();
        end
        lat_chk = 1'b1;
        send(SB'(6));
        in_valid = 1'b0; lat_chk = 1'b0;
        drain("post_reset_drain");
        dir_done = 1'b1;
      end
    end

    initial begin : random_phase
      int target;
      wait (dir_done);
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; select = '0; lat_chk = 1'b0;
      for (int k = 0; k < N; k++) lanes[k] = '0;
      tick(); tick();
      reset = 1'b0;
      target = nacc + 1000;
      for (int i = 0; i < 20000 && nacc < target; i++) begin
        for (int k = 0; k < N; k++) lanes[k] = W'($urandom);
        select    = SB'($urandom);
        in_valid  = ($urandom_range(3) != 0);
        out_ready = ($urandom_range(3) != 0);
        tick();
      end
      check($sformatf("c%0d_beats_accepted", g), nacc >= target, 1);
      in_valid = 1'b0; out_ready = 1'b1;
      drain($sformatf("c%0d_random_drain", g));
      done = 1'b1;
    end
  end

  logic all_done;
  assign all_done = cfg[0].done & cfg[1].done & cfg[2].done & cfg[3].done;

  initial begin
    for (int i = 0; i < 30000 && !all_done; i++) @(posedge clock);
    check("all_configs_finished", all_done, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
